// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, drives a 1-cycle imem and
// buffers {pc, instr} pairs in a DEPTH-entry queue toward decode.
`timescale 1ns/1ps
module fetch_queue #(
  parameter int          PC_W    = 9,
  parameter int          INS_W   = 32,
  parameter int          DEPTH   = 4,
  parameter logic [6:0]  HALT_OP = 7'b1111111
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         imem_req,
  output logic [PC_W-1:0]              imem_addr,
  input  logic [INS_W-1:0]             imem_rdata,
  input  logic                         redirect_valid,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic                         out_valid,
  output logic [PC_W-1:0]              out_pc,
  output logic [INS_W-1:0]             out_instr,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
  } entry_t;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] fpc_q, fpc_d;
  logic            req_q, req_d;
  logic            halt_q, halt_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  entry_t          mem_q [DEPTH];

  logic [CW:0] occ;
  logic        issue;
  logic        is_halt;
  logic        rsp;
  logic        push;
  logic        pop;

  // Occupancy ignores a same-cycle pop so an in-flight fetch always fits.
  assign occ     = {1'b0, cnt_q} + (CW+1)'(req_q);
  assign issue   = reset & ~redirect_valid & ~halt_q
                 & (occ < (CW+1)'(DEPTH));
  assign is_halt = (imem_rdata[6:0] == HALT_OP);
  assign rsp     = req_q & ~redirect_valid;
  assign push    = rsp & ~is_halt;
  assign pop     = out_valid & out_ready & ~redirect_valid;

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign out_valid = (cnt_q != '0);
  assign out_pc    = out_valid ? mem_q[rd_q].pc  : '0;
  assign out_instr = out_valid ? mem_q[rd_q].ins : '0;
  assign count     = cnt_q;
  assign halted    = halt_q & (cnt_q == '0) & ~req_q;

  always_comb begin
    pc_d   = pc_q;
    fpc_d  = fpc_q;
    req_d  = 1'b0;
    halt_d = halt_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      halt_d = 1'b0;
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
    end else begin
      if (issue) begin
        pc_d  = pc_q + PC_W'(4);
        fpc_d = pc_q;
        req_d = 1'b1;
      end
      if (rsp && is_halt) begin
        halt_d = 1'b1;
      end
      if (push) begin
        wr_d = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= '0;
      fpc_q  <= '0;
      req_q  <= 1'b0;
      halt_q <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      fpc_q  <= fpc_d;
      req_q  <= req_d;
      halt_q <= halt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: reads are masked by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= '{pc: fpc_q, ins: imem_rdata};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every
// negedge, plus directed literal expectations for the main scenarios.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [8:0]  redirect_pc = '0;
  logic        out_valid;
  logic [8:0]  out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b1;
  logic [2:0]  count;
  logic        halted;

  int checks = 0;
  int errors = 0;
  int halt_addr = -1;
  logic [8:0] last_a = '0;

  fetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(DEPTH),
                .HALT_OP(7'b1111111)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(logic [8:0] a, int h);
    if (int'(a) == h) return 32'h0000007F;
    return {3'b000, a, 5'd0, 3'b000, 5'd1, 7'h13};
  endfunction

  always @(posedge clk) if (imem_req) last_a <= imem_addr;
  assign imem_rdata = memf(last_a, halt_addr);

  typedef struct {
    logic [8:0]  pc;
    logic [31:0] ins;
  } ent_t;

  ent_t       mq[$];
  logic [8:0] m_pc = '0;
  logic [8:0] m_fpc = '0;
  bit         m_req = 0;
  bit         m_hs = 0;

  function automatic bit e_req();
    return reset && !redirect_valid && !m_hs
        && (mq.size() + int'(m_req) < DEPTH);
  endfunction

  task automatic model_step();
    bit iss, pop, rsp;
    logic [31:0] ins;
    if (!reset) begin
      mq.delete();
      m_pc = '0; m_fpc = '0; m_req = 0; m_hs = 0;
      return;
    end
    iss = e_req();
    pop = (mq.size() != 0) && out_ready && !redirect_valid;
    rsp = m_req && !redirect_valid;
    ins = memf(m_fpc, halt_addr);
    if (redirect_valid) begin
      mq.delete();
      m_req = 0; m_hs = 0; m_pc = redirect_pc;
    end else begin
      if (pop) void'(mq.pop_front());
      if (rsp) begin
        if (ins[6:0] == 7'h7F) m_hs = 1;
        else mq.push_back('{pc: m_fpc, ins: ins});
      end
      if (iss) begin
        m_fpc = m_pc; m_pc = m_pc + 9'd4; m_req = 1;
      end else m_req = 0;
    end
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare();
    bit v;
    v = mq.size() != 0;
    chk("m_req", 32'(imem_req), 32'(e_req()));
    chk("m_addr", 32'(imem_addr), 32'(m_pc));
    chk("m_valid", 32'(out_valid), 32'(v));
    chk("m_pc", 32'(out_pc), v ? 32'(mq[0].pc) : 32'd0);
    chk("m_instr", out_instr, v ? mq[0].ins : 32'd0);
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_halted", 32'(halted),
        32'(m_hs && mq.size() == 0 && !m_req));
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    compare();
  end

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(bit rdy, int h);
    reset = 1'b0;
    redirect_valid = 1'b0;
    out_ready = rdy;
    halt_addr = h;
    cyc(2);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    cyc(1);
    #1 chk("rst_valid", 32'(out_valid), 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_halted", 32'(halted), 0);

    // streaming
    do_reset(1, -1);
    #1 chk("t1_req", 32'(imem_req), 1);
    chk("t1_addr", 32'(imem_addr), 0);
    chk("t1_valid0", 32'(out_valid), 0);
    cyc(2);
    #1 chk("t1_pc0", 32'(out_pc), 0);
    chk("t1_ins0", out_instr, 32'h00000093);
    chk("t1_cnt", 32'(count), 1);
    cyc(1);
    #1 chk("t1_pc4", 32'(out_pc), 4);
    chk("t1_ins4", out_instr, 32'h00400093);
    cyc(6);

    // fill with decode stalled, then drain and redirect
    do_reset(0, -1);
    cyc(5);
    #1 chk("t2_cnt4", 32'(count), 4);
    chk("t2_req0", 32'(imem_req), 0);
    chk("t2_head", 32'(out_pc), 0);
    out_ready = 1'b1;
    cyc(1);
    #1 chk("t2_resume", 32'(imem_req), 1);
    chk("t2_addr16", 32'(imem_addr), 16);
    chk("t2_head4", 32'(out_pc), 4);
    cyc(1);
    #1 chk("t3_cnt2", 32'(count), 2);
    redirect_valid = 1'b1;
    redirect_pc = 9'h040;
    cyc(1);
    redirect_valid = 1'b0;
    #1 chk("t3_valid0", 32'(out_valid), 0);
    chk("t3_cnt0", 32'(count), 0);
    chk("t3_req", 32'(imem_req), 1);
    chk("t3_addr", 32'(imem_addr), 9'h040);
    cyc(1);
    #1 chk("t3_v_n2", 32'(out_valid), 0);
    cyc(1);
    #1 chk("t3_pc40", 32'(out_pc), 9'h040);
    chk("t3_ins40", out_instr, 32'h04000093);
    cyc(4);

    // halt at pc 8
    do_reset(1, 8);
    cyc(2);
    #1 chk("t4_pc0", 32'(out_pc), 0);
    cyc(1);
    #1 chk("t4_pc4", 32'(out_pc), 4);
    cyc(5);
    #1 chk("t4_halted", 32'(halted), 1);
    chk("t4_req0", 32'(imem_req), 0);
    chk("t4_valid0", 32'(out_valid), 0);
    redirect_valid = 1'b1;
    redirect_pc = 9'h020;
    cyc(1);
    redirect_valid = 1'b0;
    #1 chk("t4_unhalt", 32'(halted), 0);
    chk("t4_req1", 32'(imem_req), 1);
    chk("t4_addr20", 32'(imem_addr), 9'h020);
    cyc(5);

    // pc wrap
    halt_addr = -1;
    redirect_valid = 1'b1;
    redirect_pc = 9'h1FC;
    cyc(1);
    redirect_valid = 1'b0;
    #1 chk("t5_a1fc", 32'(imem_addr), 9'h1FC);
    cyc(1);
    #1 chk("t5_a000", 32'(imem_addr), 0);
    cyc(1);
    #1 chk("t5_pc1fc", 32'(out_pc), 9'h1FC);
    chk("t5_ins1fc", out_instr, 32'h1FC00093);
    cyc(1);
    #1 chk("t5_pc000", 32'(out_pc), 0);
    chk("t5_ins000", out_instr, 32'h00000093);
    cyc(3);

    // async reset mid-cycle
    do_reset(0, -1);
    cyc(4);
    #1 chk("t6_cnt3", 32'(count), 3);
    reset = 1'b0;
    #1 chk("t6_valid0", 32'(out_valid), 0);
    chk("t6_req0", 32'(imem_req), 0);
    chk("t6_cnt0", 32'(count), 0);
    chk("t6_addr0", 32'(imem_addr), 0);
    cyc(2);
    out_ready = 1'b1;
    reset = 1'b1;
    cyc(2);
    #1 chk("t6_pc0", 32'(out_pc), 0);
    chk("t6_ins0", out_instr, 32'h00000093);
    cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
